// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: compacts up to two fetch slots per cycle into an in-order
// circular queue and presents the oldest two entries to decode. Optional macro: FETCH_BUF_PERF_EN.
module fetch_buffer #(
   parameter int DEPTH    = 8,
   parameter int NUM_UOPS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IN_flush,
   input  logic        IN_valid,
   input  logic [63:0] IN_pc,
   input  logic [63:0] IN_instr,
   input  logic [11:0] IN_branchID,
   input  logic [1:0]  IN_branchPred,
   input  logic [1:0]  IN_instrValid,
   input  logic        IN_decReady,
   output logic        OUT_stall,
   output logic [1:0]  OUT_valid,
   output logic [63:0] OUT_pc,
   output logic [63:0] OUT_instr,
   output logic [11:0] OUT_branchID,
   output logic [1:0]  OUT_branchPred,
   output logic        OUT_overflow,
   output logic [31:0] OUT_stallCycles
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [5:0]  branch_id;
      logic        pred;
   } entry_t;

   entry_t            mem [DEPTH];
   entry_t            slot [NUM_UOPS];
   entry_t            wr_entry [NUM_UOPS];
   logic [PTR_W-1:0]  rd_ptr [NUM_UOPS];

   logic [PTR_W-1:0]  head_reg, tail_reg, tail_plus1;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [CNT_W-1:0]  free;
   logic [CNT_W-1:0]  nwr, nrd, nwr_eff;
   logic              pkt_live, accept, drop;
   logic              overflow_reg;

   generate
      for (genvar gi = 0; gi < NUM_UOPS; gi++) begin : g_slot
         assign slot[gi] = '{pc:        IN_pc[gi*32 +: 32],
                             instr:     IN_instr[gi*32 +: 32],
                             branch_id: IN_branchID[gi*6 +: 6],
                             pred:      IN_branchPred[gi]};

         assign rd_ptr[gi]                 = head_reg + PTR_W'(gi);
         assign OUT_valid[gi]              = count_reg > CNT_W'(gi);
         assign OUT_pc[gi*32 +: 32]        = mem[rd_ptr[gi]].pc;
         assign OUT_instr[gi*32 +: 32]     = mem[rd_ptr[gi]].instr;
         assign OUT_branchID[gi*6 +: 6]    = mem[rd_ptr[gi]].branch_id;
         assign OUT_branchPred[gi]         = mem[rd_ptr[gi]].pred;
      end
   endgenerate

   // Compaction: the first valid slot always lands at tail, slot 1 follows only when both are valid.
   assign wr_entry[0] = IN_instrValid[0] ? slot[0] : slot[1];
   assign wr_entry[1] = slot[1];

   assign free       = CNT_W'(DEPTH) - count_reg;
   assign nwr        = CNT_W'(IN_instrValid[0]) + CNT_W'(IN_instrValid[1]);
   assign pkt_live   = IN_valid && !IN_flush;
   assign drop       = pkt_live && (nwr > free);
   assign accept     = pkt_live && !drop && (nwr != '0);
   assign nwr_eff    = accept ? nwr : '0;
   assign nrd        = (IN_decReady && !IN_flush) ?
                       (CNT_W'(OUT_valid[0]) + CNT_W'(OUT_valid[1])) : '0;
   assign count_next = count_reg + nwr_eff - nrd;
   assign tail_plus1 = tail_reg + PTR_W'(1);

   // Space check ignores same-cycle reads so the stall stays a pure function of count.
   assign OUT_stall    = free < CNT_W'(4);
   assign OUT_overflow = overflow_reg;

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[tail_reg] <= wr_entry[0];
         if (nwr == CNT_W'(2)) begin
            mem[tail_plus1] <= wr_entry[1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || IN_flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_reg + nrd[PTR_W-1:0];
         tail_reg  <= tail_reg + nwr_eff[PTR_W-1:0];
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_reg <= 1'b0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
      end
   end

`ifdef FETCH_BUF_PERF_EN
   logic [31:0] stall_cycles_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_reg <= '0;
      end else if (OUT_stall) begin
         stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
   end

   assign OUT_stallCycles = stall_cycles_reg;
`else
   assign OUT_stallCycles = '0;
`endif

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch buffer between the program-counter/fetch stage and decode. Accepts up to two 32-bit fetch slots per cycle (PC, instruction word, branch ID, predicted-taken flag, per-slot valid), compacts away invalid slots, and stores them in an in-order circular queue. Presents the oldest two entries to decode and returns a stall that drives the fetch stage's enables. Cleared on a redirect flush.

## Interface

- DEPTH, 8, queue entries (one instruction each); power of two, ≥ 4
- NUM_UOPS, 2, slots per input packet and per output group; fixed at 2

- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- IN_flush  in  1  redirect/mispredict; empties queue
- IN_valid  in  1  fetch packet present this cycle
- IN_pc  in  64  slot i PC at [i*32+:32]
- IN_instr  in  64  slot i instruction at [i*32+:32]
- IN_branchID  in  12  slot i branch ID at [i*6+:6]; 63 = no branch
- IN_branchPred  in  2  slot i predicted taken
- IN_instrValid  in  2  slot i valid
- IN_decReady  in  1  decode consumes every presented valid output this cycle
- OUT_stall  out  1  fetch must not advance (inverted into en0/en1 upstream)
- OUT_valid  out  2  output slot valid
- OUT_pc  out  64  output PCs, same packing as IN_pc
- OUT_instr  out  64  output instruction words
- OUT_branchID  out  12  output branch IDs
- OUT_branchPred  out  2  output predictions
- OUT_overflow  out  1  sticky: a valid slot was dropped for lack of space
- OUT_stallCycles  out  32  cycles with OUT_stall high (see Configuration)

## Operation

- State: entry array [DEPTH] of {pc 32, instr 32, branchID 6, pred 1}; head, tail pointers, log2(DEPTH) bits, wrap modulo DEPTH; count, log2(DEPTH)+1 bits.
- Write: when IN_valid && !IN_flush, nwr = popcount(IN_instrValid). Valid slots are written in slot order starting at tail (slot 1 alone goes to tail; both: slot 0 at tail, slot 1 at tail+1). tail += nwr.
- Space check uses free = DEPTH − count of the current cycle (no credit for same-cycle reads). If nwr > free, the entire packet is dropped, tail unchanged, OUT_overflow set. It stays set until rst; flush does not clear it.
- Read: OUT_valid[0] = count ≥ 1 and OUT_valid[1] = count ≥ 2. Output slot j shows entry head+j (mod DEPTH), combinationally from the array. When IN_decReady, nrd = popcount(OUT_valid) and head += nrd.
- count_next = count + nwr − nrd. A simultaneous read and write in any combination is legal.
- OUT_stall = (free < 4). It is combinational from count only, so one in-flight packet always fits after the stall asserts.
- Flush: head = tail = count = 0 next cycle. The input packet in the flush cycle is discarded. IN_decReady is ignored in the flush cycle. Array contents need not be cleared.
- Field values pass through unmodified, including branchID 63 and pred.
- Output data fields are don't-care when the corresponding OUT_valid bit is low.

## Timing

- Input to output latency: 1 cycle. An entry written at edge t is visible from t+1. There is no empty-bypass.
- Read side: outputs update after the edge where head advances.
- rst (same priority as flush, and it also clears OUT_overflow and OUT_stallCycles) takes effect at the next edge. Reset values: OUT_valid = 0, OUT_stall = 0, OUT_overflow = 0, OUT_stallCycles = 0, head = tail = count = 0.
- rst or flush mid-stream: all queued entries are lost. The next packet is accepted on the following cycle.
- Full boundary, DEPTH = 8: count 5–8 → stall = 1; count ≤ 4 → stall = 0. count = 7 with nwr = 2 and no read → drop plus overflow. count = 7 with nwr = 1 → accepted, count = 8.
- Empty boundary: count = 0 with IN_decReady → nrd = 0, head unchanged.

## Configuration

- FETCH_BUF_PERF_EN defined: OUT_stallCycles is a 32-bit counter that increments on every cycle OUT_stall = 1 after reset. It wraps at 2^32, clears only on rst, and is unaffected by flush.
- Not defined: OUT_stallCycles is tied to 0 and no counter is instantiated. All other behaviour is identical.

## Test plan

- Reset, then packet with PCs 0x100/0x104, valid 2'b11 → next cycle OUT_valid = 11, OUT_pc = {0x104, 0x100}; with decReady high, OUT_valid = 00 the following cycle.
- Packet valid 2'b10 (slot 1 PC 0x206, branchID 5, pred 1) into an empty buffer → OUT_valid = 01, OUT_pc[31:0] = 0x206, OUT_branchID[5:0] = 5, OUT_branchPred[0] = 1.
- Four full packets with decReady low → count 8, OUT_stall high from count 6. A fifth packet (valid 11) → dropped, OUT_overflow = 1, and the head is still the first PC.
- Steady state, write 2 and read 2 every cycle across 20 cycles → PC order is preserved across the pointer wrap, count is constant at 2, and there is no overflow.
- Buffer holding 6 entries, IN_flush together with a valid packet → next cycle OUT_valid = 00, OUT_stall = 0. A new packet at PC 0x400 appears as the head one cycle later.
- With FETCH_BUF_PERF_EN: 10 stalled cycles → OUT_stallCycles = 10, which survives a flush. Without the macro it reads 0.
